// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a valid/ready load port and registered
// serial outputs (data bit, valid, last-bit marker).
module bit_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_BIT   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Load_Valid,
    output logic                  Load_Ready,
    output logic                  Ser_Out,
    output logic                  Ser_Valid,
    output logic                  Last
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cnt_inc;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  ser_out_q, ser_out_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  last_q, last_d;
    logic                  final_bit;
    logic                  load;

    assign cnt_inc    = cnt_q + CW'(1);
    assign final_bit  = (state_q == SHIFT) && (cnt_q == CNT_MAX);
    assign Load_Ready = (state_q == IDLE) || final_bit;
    assign load       = Load_Valid && Load_Ready;

    assign Ser_Out   = ser_out_q;
    assign Ser_Valid = ser_valid_q;
    assign Last      = last_q;

    // shreg holds the bits still to be presented; the current bit lives in ser_out_q
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        last_d      = last_q;
        if (load) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            last_d      = 1'b0;
            if (MSB_FIRST) begin
                ser_out_d = Data_In[DATA_WIDTH-1];
                shreg_d   = {Data_In[DATA_WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = Data_In[0];
                shreg_d   = {1'b0, Data_In[DATA_WIDTH-1:1]};
            end
        end else if (final_bit) begin
            state_d     = IDLE;
            cnt_d       = '0;
            ser_out_d   = IDLE_BIT;
            ser_valid_d = 1'b0;
            last_d      = 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_d       = cnt_inc;
            ser_valid_d = 1'b1;
            last_d      = (cnt_inc == CNT_MAX);
            if (MSB_FIRST) begin
                ser_out_d = shreg_q[DATA_WIDTH-1];
                shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = shreg_q[0];
                shreg_d   = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            last_q      <= last_d;
        end
    end

endmodule
